// File: rtl/xpb_table_gen_if.sv
// Output stream of the XPB table generator: one (address, data) entry per
// valid/ready handshake, feeding the table RAM/ROM loader.
interface xpb_table_gen_if #(
    parameter int DATA_W = 1024,
    parameter int IDX_W  = 5
);
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/xpb_table_gen.sv
// XPB reduction table writer: streams k*B mod M for k = 0 .. 2^IDX_W-1.
// Each next entry is built as acc+B, with a conditional subtract of M, in a
// limb-serial datapath. The operand registers rotate one limb per ADD cycle,
// so the active limb is always the low LIMB_W bits. After NL rotations they
// are back in their original alignment. The sum and difference registers
// shift in from the top, so after NL cycles limb 0 sits at the bottom.
module xpb_table_gen #(
    parameter int DATA_W = 1024,
    parameter int LIMB_W = 64,
    parameter int IDX_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DATA_W-1:0]  modulus,
    input  logic [DATA_W-1:0]  base,
    output logic               busy,
    output logic               done,
    xpb_table_gen_if.master    out_if
);
    localparam int NL  = DATA_W / LIMB_W;
    localparam int L_W = (NL > 1) ? $clog2(NL) : 1;
    localparam logic [IDX_W-1:0] KMAX   = '1;
    localparam logic [L_W-1:0]   L_LAST = L_W'(NL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_ADD,
        S_SEL
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] diff_q;
    logic              carry_q;
    logic              borrow_q;
    logic [L_W-1:0]    l_q;
    logic [IDX_W-1:0]  k_q;
    logic              done_q;

    logic [LIMB_W:0]   limb_sum;
    logic [LIMB_W:0]   limb_diff;

    // One limb of acc+B+carry, and of (that limb)-M-borrow. The top bit of each result is the carry or borrow out.
    always_comb begin
        limb_sum  = {1'b0, acc_q[LIMB_W-1:0]} + {1'b0, b_q[LIMB_W-1:0]}
                  + {{LIMB_W{1'b0}}, carry_q};
        limb_diff = {1'b0, limb_sum[LIMB_W-1:0]} - {1'b0, m_q[LIMB_W-1:0]}
                  - {{LIMB_W{1'b0}}, borrow_q};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The last entry's handshake returns to IDLE instead of computing another entry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_EMIT;
            S_EMIT: if (out_if.out_ready) state_d = (k_q == KMAX) ? S_IDLE : S_ADD;
            S_ADD:  if (l_q == L_LAST) state_d = S_SEL;
            S_SEL:  state_d = S_EMIT;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: latch the operands, walk the limbs, and select the reduced result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            sum_q    <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            l_q      <= '0;
            k_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        m_q   <= modulus;
                        b_q   <= base;
                        acc_q <= '0;
                        k_q   <= '0;
                    end
                end
                S_EMIT: begin
                    if (out_if.out_ready) begin
                        if (k_q == KMAX) begin
                            done_q <= 1'b1;
                        end else begin
                            k_q      <= k_q + IDX_W'(1);
                            l_q      <= '0;
                            carry_q  <= 1'b0;
                            borrow_q <= 1'b0;
                        end
                    end
                end
                S_ADD: begin
                    acc_q    <= (acc_q >> LIMB_W) | (acc_q << (DATA_W - LIMB_W));
                    b_q      <= (b_q >> LIMB_W) | (b_q << (DATA_W - LIMB_W));
                    m_q      <= (m_q >> LIMB_W) | (m_q << (DATA_W - LIMB_W));
                    sum_q    <= (sum_q >> LIMB_W)
                              | (DATA_W'(limb_sum[LIMB_W-1:0]) << (DATA_W - LIMB_W));
                    diff_q   <= (diff_q >> LIMB_W)
                              | (DATA_W'(limb_diff[LIMB_W-1:0]) << (DATA_W - LIMB_W));
                    carry_q  <= limb_sum[LIMB_W];
                    borrow_q <= limb_diff[LIMB_W];
                    l_q      <= l_q + L_W'(1);
                end
                S_SEL: begin
                    // acc+B >= M exactly when the sum overflowed or the subtraction did not underflow.
                    acc_q <= (carry_q | ~borrow_q) ? diff_q : sum_q;
                end
                default: ;
            endcase
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign out_if.out_valid = (state_q == S_EMIT);
    assign out_if.out_addr  = k_q;
    assign out_if.out_data  = acc_q;
endmodule
